// File: rtl/ps2_piano_pkg.sv
// Shared definitions for the voice scheduler: slot state encoding, reserved
// note codes and default sizing.
package ps2_piano_pkg;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    HELD    = 2'd1,
    RELEASE = 2'd2
  } voice_state_e;

  localparam int NOTE_NONE     = 0;
  localparam int NOTE_RELEASE  = 99;
  localparam int DEF_NOTE_W    = 7;
  localparam int DEF_REL_TICKS = 3;
  localparam int TIMER_W       = 8;

endpackage

// File: rtl/ps2_voice_scheduler_voice_slot.sv
// voice_slot: one voice slot's state, note, release timer and age registers.
// Ports:
//   iClk, iReset_n     clock, async active-low reset
//   assign_en/_note    load note, enter HELD, clear age (wins over all else)
//   rel_match          slot is HELD with the released note: enter RELEASE
//   tick               timebase strobe, counts down the release tail
//   state/note/timer/age  current register values
module voice_slot
  import ps2_piano_pkg::*;
#(
  parameter int NOTE_W    = DEF_NOTE_W,
  parameter int AGE_W     = 8,
  parameter int REL_TICKS = DEF_REL_TICKS
) (
  input  logic                iClk,
  input  logic                iReset_n,
  input  logic                assign_en,
  input  logic [NOTE_W-1:0]   assign_note,
  input  logic                rel_match,
  input  logic                tick,
  output voice_state_e        state,
  output logic [NOTE_W-1:0]   note,
  output logic [TIMER_W-1:0]  timer,
  output logic [AGE_W-1:0]    age
);

  voice_state_e        state_q, state_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [AGE_W-1:0]    age_q, age_d;

  always_comb begin
    state_d = state_q;
    note_d  = note_q;
    timer_d = timer_q;
    age_d   = age_q;
    if (state_q != FREE && age_q != '1) age_d = age_q + 1'b1;
    if (state_q == RELEASE && tick) begin
      if (timer_q == '0) state_d = FREE;
      else               timer_d = timer_q - 1'b1;
    end
    if (rel_match) begin
      state_d = RELEASE;
      timer_d = TIMER_W'(REL_TICKS - 1);
    end
    // A press landing on this slot overrides any expiry in the same cycle.
    if (assign_en) begin
      state_d = HELD;
      note_d  = assign_note;
      age_d   = '0;
    end
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q <= FREE;
      note_q  <= '0;
      timer_q <= '0;
      age_q   <= '0;
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      timer_q <= timer_d;
      age_q   <= age_d;
    end
  end

  assign state = state_q;
  assign note  = note_q;
  assign timer = timer_q;
  assign age   = age_q;

endmodule

// File: rtl/ps2_voice_scheduler.sv
// ps2_voice_scheduler: polyphonic voice allocator. Press events are mapped to
// voice slots (re-trigger, free, shortest release tail, oldest held steal);
// release events start a timed tail paced by iTick.
// Ports:
//   iClk, iReset_n                  clock, async active-low reset
//   iTick                           release-tail timebase strobe
//   iEventValid/iEventRelease/iNote note event (note 0 ignored)
//   oVoiceNote/oVoiceGate/oVoiceBusy per-slot note, HELD, HELD|RELEASE
//   oAllocValid/oAllocIdx/oSteal    registered allocation pulse
module ps2_voice_scheduler
  import ps2_piano_pkg::*;
#(
  parameter int VOICES    = 4,
  parameter int NOTE_W    = DEF_NOTE_W,
  parameter int REL_TICKS = DEF_REL_TICKS,
  parameter int AGE_W     = 8,
  localparam int IDX_W    = $clog2(VOICES)
) (
  input  logic                     iClk,
  input  logic                     iReset_n,
  input  logic                     iTick,
  input  logic                     iEventValid,
  input  logic                     iEventRelease,
  input  logic [NOTE_W-1:0]        iNote,
  output logic [VOICES*NOTE_W-1:0] oVoiceNote,
  output logic [VOICES-1:0]        oVoiceGate,
  output logic [VOICES-1:0]        oVoiceBusy,
  output logic                     oAllocValid,
  output logic [IDX_W-1:0]         oAllocIdx,
  output logic                     oSteal
);

  voice_state_e        slot_state [VOICES];
  logic [NOTE_W-1:0]   slot_note  [VOICES];
  logic [TIMER_W-1:0]  slot_timer [VOICES];
  logic [AGE_W-1:0]    slot_age   [VOICES];
  logic [VOICES-1:0]   assign_vec, rel_vec;

  logic               press, rel_ev, held_hit;
  logic               f_rn, f_free, f_rel, f_held;
  logic [IDX_W-1:0]   i_rn, i_free, i_rel, i_held;
  logic [TIMER_W-1:0] best_timer;
  logic [AGE_W-1:0]   best_age;
  logic               sel_found, sel_steal;
  logic [IDX_W-1:0]   sel_idx;

  logic               alloc_valid_q, alloc_valid_d;
  logic [IDX_W-1:0]   alloc_idx_q, alloc_idx_d;
  logic               steal_q, steal_d;

  always_comb begin
    press    = iEventValid && !iEventRelease && (iNote != NOTE_W'(NOTE_NONE));
    rel_ev   = iEventValid &&  iEventRelease && (iNote != NOTE_W'(NOTE_NONE));
    held_hit = 1'b0;
    rel_vec  = '0;
    f_rn = 1'b0; f_free = 1'b0; f_rel = 1'b0; f_held = 1'b0;
    i_rn = '0;   i_free = '0;   i_rel = '0;   i_held = '0;
    best_timer = '0;
    best_age   = '0;
    // Descending scan so the lowest matching index is the last one written.
    for (int k = VOICES - 1; k >= 0; k--) begin
      if (slot_state[k] == HELD && slot_note[k] == iNote) held_hit = 1'b1;
      rel_vec[k] = rel_ev && slot_state[k] == HELD && slot_note[k] == iNote;
      if (slot_state[k] == RELEASE && slot_note[k] == iNote) begin
        f_rn = 1'b1; i_rn = IDX_W'(k);
      end
      if (slot_state[k] == FREE) begin
        f_free = 1'b1; i_free = IDX_W'(k);
      end
    end
    // Ascending scan with strict compares keeps the lowest index on ties.
    for (int k = 0; k < VOICES; k++) begin
      if (slot_state[k] == RELEASE && (!f_rel || slot_timer[k] < best_timer)) begin
        f_rel = 1'b1; i_rel = IDX_W'(k); best_timer = slot_timer[k];
      end
      if (slot_state[k] == HELD && (!f_held || slot_age[k] > best_age)) begin
        f_held = 1'b1; i_held = IDX_W'(k); best_age = slot_age[k];
      end
    end
    sel_found = press && !held_hit;
    sel_steal = 1'b0;
    if      (f_rn)   sel_idx = i_rn;
    else if (f_free) sel_idx = i_free;
    else if (f_rel)  sel_idx = i_rel;
    else begin
      sel_idx   = i_held;
      sel_steal = sel_found;
    end
    for (int k = 0; k < VOICES; k++)
      assign_vec[k] = sel_found && (sel_idx == IDX_W'(k));
    alloc_valid_d = sel_found;
    alloc_idx_d   = sel_found ? sel_idx : '0;
    steal_d       = sel_steal;
  end

  for (genvar k = 0; k < VOICES; k++) begin : g_slot
    voice_slot #(
      .NOTE_W(NOTE_W), .AGE_W(AGE_W), .REL_TICKS(REL_TICKS)
    ) u_slot (
      .iClk        (iClk),
      .iReset_n    (iReset_n),
      .assign_en   (assign_vec[k]),
      .assign_note (iNote),
      .rel_match   (rel_vec[k]),
      .tick        (iTick),
      .state       (slot_state[k]),
      .note        (slot_note[k]),
      .timer       (slot_timer[k]),
      .age         (slot_age[k])
    );
    assign oVoiceNote[k*NOTE_W +: NOTE_W] = slot_note[k];
    assign oVoiceGate[k] = (slot_state[k] == HELD);
    assign oVoiceBusy[k] = (slot_state[k] != FREE);
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      alloc_valid_q <= 1'b0;
      alloc_idx_q   <= '0;
      steal_q       <= 1'b0;
    end else begin
      alloc_valid_q <= alloc_valid_d;
      alloc_idx_q   <= alloc_idx_d;
      steal_q       <= steal_d;
    end
  end

  assign oAllocValid = alloc_valid_q;
  assign oAllocIdx   = alloc_idx_q;
  assign oSteal      = steal_q;

endmodule

// File: tb/tb_ps2_voice_scheduler.sv
module tb_ps2_voice_scheduler;
  localparam int V  = 4;
  localparam int NW = 7;
  localparam int RT = 3;
  localparam int AMAX = 255;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          tick = 0, ev_valid = 0, ev_rel = 0;
  logic [NW-1:0] note = 0;
  logic [V*NW-1:0] v_note;
  logic [V-1:0]  v_gate, v_busy;
  logic          a_valid, steal;
  logic [1:0]    a_idx;

  int vectors = 0, errors = 0;

  // Reference model: 0=free 1=held 2=release
  int m_st [V], m_nt [V], m_tm [V], m_ag [V];
  int e_av, e_idx, e_st;

  always #5 clk = ~clk;

  ps2_voice_scheduler #(.VOICES(V), .NOTE_W(NW), .REL_TICKS(RT), .AGE_W(8)) dut (
    .iClk(clk), .iReset_n(rst_n), .iTick(tick), .iEventValid(ev_valid),
    .iEventRelease(ev_rel), .iNote(note), .oVoiceNote(v_note), .oVoiceGate(v_gate),
    .oVoiceBusy(v_busy), .oAllocValid(a_valid), .oAllocIdx(a_idx), .oSteal(steal));

  function automatic void model_reset();
    for (int k = 0; k < V; k++) begin m_st[k] = 0; m_nt[k] = 0; m_tm[k] = 0; m_ag[k] = 0; end
    e_av = 0; e_idx = 0; e_st = 0;
  endfunction

  function automatic void model_step(input bit v, input bit r, input int n, input bit t);
    int ps [V], pn [V], pt [V], pa [V];
    int sel;
    for (int k = 0; k < V; k++) begin ps[k] = m_st[k]; pn[k] = m_nt[k]; pt[k] = m_tm[k]; pa[k] = m_ag[k]; end
    e_av = 0; e_st = 0; e_idx = 0;
    for (int k = 0; k < V; k++) begin
      if (ps[k] != 0 && pa[k] < AMAX) m_ag[k] = pa[k] + 1;
      if (ps[k] == 2 && t) begin
        if (pt[k] == 0) m_st[k] = 0; else m_tm[k] = pt[k] - 1;
      end
    end
    if (v && n != 0) begin
      if (r) begin
        for (int k = 0; k < V; k++)
          if (ps[k] == 1 && pn[k] == n) begin m_st[k] = 2; m_tm[k] = RT - 1; end
      end else begin
        bit dup = 0;
        sel = -1;
        for (int k = 0; k < V; k++) if (ps[k] == 1 && pn[k] == n) dup = 1;
        if (!dup) begin
          for (int k = 0; k < V && sel < 0; k++) if (ps[k] == 2 && pn[k] == n) sel = k;
          for (int k = 0; k < V && sel < 0; k++) if (ps[k] == 0) sel = k;
          if (sel < 0) begin
            int best = 1 << 30;
            for (int k = 0; k < V; k++) if (ps[k] == 2 && pt[k] < best) begin best = pt[k]; sel = k; end
          end
          if (sel < 0) begin
            int best = -1;
            for (int k = 0; k < V; k++) if (pa[k] > best) begin best = pa[k]; sel = k; end
            e_st = 1;
          end
          m_st[sel] = 1; m_nt[sel] = n; m_ag[sel] = 0;
          e_av = 1; e_idx = sel;
        end
      end
    end
  endfunction

  function automatic logic [V-1:0] m_gate();
    logic [V-1:0] g;
    for (int k = 0; k < V; k++) g[k] = (m_st[k] == 1);
    return g;
  endfunction

  function automatic logic [V-1:0] m_busy();
    logic [V-1:0] b;
    for (int k = 0; k < V; k++) b[k] = (m_st[k] != 0);
    return b;
  endfunction

  function automatic logic [V*NW-1:0] m_notes();
    logic [V*NW-1:0] x;
    for (int k = 0; k < V; k++) x[k*NW +: NW] = NW'(m_nt[k]);
    return x;
  endfunction

  task automatic cyc(input bit v, input bit r, input int n, input bit t);
    @(negedge clk);
    ev_valid = v; ev_rel = r; note = NW'(n); tick = t;
    @(posedge clk);
    model_step(v, r, n, t);
    #1;
    ev_valid = 0; tick = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; ev_valid = 0; tick = 0;
    model_reset();
    #2 rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    model_reset();
    #12;
    vectors++; if (v_gate !== 0) begin errors++; $display("FAIL reset_gate got %b want 0", v_gate); end
    vectors++; if (v_busy !== 0) begin errors++; $display("FAIL reset_busy got %b want 0", v_busy); end
    vectors++; if (v_note !== 0) begin errors++; $display("FAIL reset_note got %h want 0", v_note); end
    vectors++; if ({a_valid, a_idx, steal} !== 0) begin errors++; $display("FAIL reset_pulse got %b%b%b want 0", a_valid, a_idx, steal); end
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_first_press();
    cyc(1, 0, 32, 0);
    vectors++; if (v_gate !== 4'b0001) begin errors++; $display("FAIL first_gate got %b want 0001", v_gate); end
    vectors++; if (v_note[6:0] !== 7'd32) begin errors++; $display("FAIL first_note got %0d want 32", v_note[6:0]); end
    vectors++; if (a_valid !== 1'b1 || a_idx !== 2'd0 || steal !== 1'b0) begin errors++; $display("FAIL first_alloc got v%b i%0d s%b want v1 i0 s0", a_valid, a_idx, steal); end
    cyc(0, 0, 0, 0);
    vectors++; if (a_valid !== 1'b0) begin errors++; $display("FAIL first_pulse_end got %b want 0", a_valid); end
  endtask

  task automatic test_steal();
    do_reset();
    cyc(1, 0, 32, 0); cyc(1, 0, 34, 0); cyc(1, 0, 36, 0); cyc(1, 0, 37, 0);
    vectors++; if (v_gate !== 4'b1111) begin errors++; $display("FAIL steal_full got %b want 1111", v_gate); end
    cyc(1, 0, 39, 0);
    vectors++; if (steal !== 1'b1 || a_valid !== 1'b1 || a_idx !== 2'd0) begin errors++; $display("FAIL steal_pulse got v%b i%0d s%b want v1 i0 s1", a_valid, a_idx, steal); end
    vectors++; if (v_note[6:0] !== 7'd39) begin errors++; $display("FAIL steal_note got %0d want 39", v_note[6:0]); end
  endtask

  task automatic test_release_tail();
    do_reset();
    cyc(1, 0, 32, 0); cyc(1, 0, 34, 0); cyc(1, 1, 34, 0);
    vectors++; if (v_gate !== 4'b0001 || v_busy !== 4'b0011) begin errors++; $display("FAIL tail_enter got g%b b%b want g0001 b0011", v_gate, v_busy); end
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 0); cyc(0, 0, 0, 1);
    vectors++; if (v_busy[1] !== 1'b1) begin errors++; $display("FAIL tail_2ticks got %b want 1", v_busy[1]); end
    cyc(0, 0, 0, 1);
    vectors++; if (v_busy !== 4'b0001) begin errors++; $display("FAIL tail_expire got %b want 0001", v_busy); end
    vectors++; if (v_note[13:7] !== 7'd34) begin errors++; $display("FAIL tail_keep_note got %0d want 34", v_note[13:7]); end
  endtask

  task automatic test_repress();
    do_reset();
    cyc(1, 0, 32, 0); cyc(1, 0, 34, 0); cyc(1, 1, 34, 0);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    cyc(1, 0, 34, 1);  // press coincides with the expiring tick: press wins
    vectors++; if (v_gate !== 4'b0011 || a_valid !== 1'b1 || a_idx !== 2'd1 || steal !== 1'b0) begin
      errors++; $display("FAIL repress got g%b v%b i%0d s%b want g0011 v1 i1 s0", v_gate, a_valid, a_idx, steal); end
  endtask

  task automatic test_duplicate();
    do_reset();
    cyc(1, 0, 32, 0); cyc(1, 0, 32, 0);
    vectors++; if (a_valid !== 1'b0 || v_gate !== 4'b0001 || v_note !== m_notes()) begin
      errors++; $display("FAIL duplicate got v%b g%b n%h want v0 g0001 n%h", a_valid, v_gate, v_note, m_notes()); end
  endtask

  task automatic test_ignored();
    cyc(1, 1, 50, 0);
    vectors++; if (a_valid !== 1'b0 || v_busy !== 4'b0001 || v_gate !== 4'b0001) begin errors++; $display("FAIL ign_release got v%b b%b g%b want v0 b0001 g0001", a_valid, v_busy, v_gate); end
    cyc(1, 0, 0, 0);
    vectors++; if (a_valid !== 1'b0 || v_busy !== 4'b0001) begin errors++; $display("FAIL ign_note0 got v%b b%b want v0 b0001", a_valid, v_busy); end
    cyc(1, 1, 0, 0);
    vectors++; if (v_gate !== 4'b0001) begin errors++; $display("FAIL ign_rel0 got %b want 0001", v_gate); end
    cyc(0, 0, 40, 0);
    vectors++; if (a_valid !== 1'b0 || v_busy !== 4'b0001) begin errors++; $display("FAIL ign_novalid got v%b b%b want v0 b0001", a_valid, v_busy); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cyc(1, 0, 32, 0); cyc(1, 0, 34, 0); cyc(1, 0, 36, 0); cyc(1, 1, 36, 0); cyc(0, 0, 0, 1);
    #2 rst_n = 0;
    model_reset();
    #1;
    vectors++; if (v_gate !== 0 || v_busy !== 0 || v_note !== 0 || a_valid !== 0 || steal !== 0) begin
      errors++; $display("FAIL mid_reset got g%b b%b n%h v%b s%b want all 0", v_gate, v_busy, v_note, a_valid, steal); end
    @(negedge clk); rst_n = 1;
    cyc(1, 0, 36, 0);
    vectors++; if (a_valid !== 1'b1 || a_idx !== 2'd0 || v_gate !== 4'b0001) begin errors++; $display("FAIL mid_after got v%b i%0d g%b want v1 i0 g0001", a_valid, a_idx, v_gate); end
  endtask

  task automatic test_random();
    int n;
    bit v, r, t;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(3) != 0);
      r = ($urandom_range(2) == 0);
      n = ($urandom_range(9) == 0) ? 0 : 30 + $urandom_range(6);
      t = ($urandom_range(2) == 0);
      cyc(v, r, n, t);
      vectors++; if (v_gate !== m_gate()) begin errors++; $display("FAIL rnd_gate @%0d got %b want %b", i, v_gate, m_gate()); end
      vectors++; if (v_busy !== m_busy()) begin errors++; $display("FAIL rnd_busy @%0d got %b want %b", i, v_busy, m_busy()); end
      vectors++; if (v_note !== m_notes()) begin errors++; $display("FAIL rnd_note @%0d got %h want %h", i, v_note, m_notes()); end
      vectors++; if (a_valid !== e_av[0] || steal !== e_st[0]) begin errors++; $display("FAIL rnd_pulse @%0d got v%b s%b want v%0d s%0d", i, a_valid, steal, e_av, e_st); end
      if (e_av != 0) begin
        vectors++; if (a_idx !== e_idx[1:0]) begin errors++; $display("FAIL rnd_idx @%0d got %0d want %0d", i, a_idx, e_idx); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_press();
    test_steal();
    test_release_tail();
    test_repress();
    test_duplicate();
    test_ignored();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/ps2_voice_scheduler.md
# ps2_voice_scheduler

Polyphonic voice allocator between the keyboard note decoding path and a bank of tone-generator voices. It accepts press and release note events and assigns each pressed note to one of VOICES voice slots. It holds each slot through a timed release tail, then frees it. When every slot is occupied it steals a slot by a fixed age/priority rule. Its outputs drive the per-voice note and gate inputs of the tone generators.

## Interface
- VOICES, 4: number of voice slots (2..8).
- NOTE_W, 7: note index width; must hold note codes 1..99.
- REL_TICKS, 3: release-tail length in iTick pulses (1..255).
- AGE_W, 8: width of the saturating per-voice age counter.
- iClk  in  1  system clock; all state changes on the rising edge.
- iReset_n  in  1  asynchronous, active-low reset.
- iTick  in  1  single-cycle timebase strobe that paces the release tails.
- iEventValid  in  1  single-cycle event strobe; one event can be accepted every cycle.
- iEventRelease  in  1  qualifies iEventValid: 1 means release, 0 means press.
- iNote  in  NOTE_W  note of the event; 0 means no note, and the event is ignored.
- oVoiceNote  out  VOICES*NOTE_W  packed note per slot; slot k occupies bits [k*NOTE_W +: NOTE_W].
- oVoiceGate  out  VOICES  slot is in the HELD state.
- oVoiceBusy  out  VOICES  slot is in the HELD or RELEASE state.
- oAllocValid  out  1  one-cycle pulse: a press event was assigned to a slot.
- oAllocIdx  out  $clog2(VOICES)  slot assigned; valid while oAllocValid is 1.
- oSteal  out  1  one-cycle pulse: the assignment evicted a HELD slot.

## Operation
- Each slot is in one of three states: FREE, HELD or RELEASE. Each slot holds note, timer (8 bit) and age (AGE_W bits).
- Age behaviour:
  - Age clears to 0 when the slot is assigned.
  - Age increments by 1 every cycle the slot is busy.
  - Age saturates at all-ones.
- The tick runs every slot in RELEASE:
  - On iTick, timer decrements by 1.
  - When timer == 0 on iTick, the slot goes to FREE.
- A press of note n is handled in this priority order:
  1. A HELD slot already has note n: the event is ignored. There is no allocation pulse.
  2. A RELEASE slot has note n: that slot goes back to HELD and age clears. This counts as an allocation.
  3. Otherwise, the lowest-index FREE slot is used.
  4. Otherwise, the RELEASE slot with the smallest timer is used. On a tie, the lowest index wins.
  5. Otherwise, the HELD slot with the largest age is stolen. On a tie, the lowest index wins. oSteal pulses.
- In cases 2–5 the chosen slot gets note n, goes to HELD, and age clears.
- A release of note n: every HELD slot with note n goes to RELEASE, with timer = REL_TICKS-1. A release that matches no HELD slot is ignored.
- Release never affects a slot that is already in RELEASE.
- A slot returning to FREE keeps its oVoiceNote value; only oVoiceBusy and oVoiceGate drop.

## Timing
- Reset value of every output is 0; every slot state is FREE, with note, timer and age at 0.
- Event latency is 1 cycle: an event at edge t is visible on the outputs after edge t.
- Tick latency is the same: a tick at edge t frees the slot after edge t.
- oAllocValid, oAllocIdx and oSteal are registered pulses, aligned with the slot update.
- When a tick expiry and a press event occur in the same cycle, selection uses the pre-edge states:
  - The expiring slot still counts as RELEASE.
  - If the press chooses that slot, the slot becomes HELD; the press wins.
- A release event and a tick in the same cycle, on the same slot in HELD: the slot enters RELEASE with timer REL_TICKS-1. The tick is not applied to it in that cycle.
- Reset asserted mid-operation clears all slots at once, without waiting for a clock edge. No pulses are emitted after reset.
- Any iEventRelease or iNote value is ignored when iEventValid is 0.

## Structure
- Package ps2_piano_pkg:
  - Voice state encoding: FREE=2'd0, HELD=2'd1, RELEASE=2'd2.
  - NOTE_NONE=0.
  - NOTE_RELEASE=99.
  - Default values of NOTE_W and REL_TICKS.
- Sub-module voice_slot is instantiated VOICES times:
  - It holds one slot's state, note, timer and age registers, and the next-state logic for them.
  - Its inputs are assign, release-match and tick.
  - It exports state, note, timer and age.
- The top level holds the match, selection and priority logic, plus the output registers.

## Test plan
- Reset, then press 32 → after 1 cycle: oVoiceGate=0001, slot0 note=32, oAllocValid=1, oAllocIdx=0, oSteal=0; all outputs were 0 before the press.
- Steal:
  - Presses 32, 34, 36, 37 on consecutive cycles → gates 1111.
  - Then press 39 → oSteal=1, oAllocIdx=0, slot0 note=39.
- Release tail (REL_TICKS=3): after 32 and 34 are pressed, release 34 → slot1 gate=0, busy=1. Then:
  - After 2 iTicks, slot1 is still busy.
  - The 3rd iTick → busy=0.
  - Re-press 34 before the 3rd tick instead → slot1 is reused, gate=1, oSteal=0.
- Duplicate press: press 32 twice → the second press gives no allocation pulse and the state is unchanged.
- Release of 50 (never pressed), or any event with iNote=0 → no state change and no pulses.
- With 3 slots busy and one slot in RELEASE, assert iReset_n=0 mid-tail → all outputs are 0 at once. After reset is removed, press 36 → goes to slot 0.
